// File: rtl/light_pkg.sv
// Shared light-code, fault-code and monitor state definitions.
// Imported by the intersection controller and light_monitor.
package light_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BADLT  = 2'd3;

  localparam logic [2:0] F_NONE        = 3'd0;
  localparam logic [2:0] F_INVALID     = 3'd1;
  localparam logic [2:0] F_CONFLICT    = 3'd2;
  localparam logic [2:0] F_ILLEGAL_SEQ = 3'd3;
  localparam logic [2:0] F_SHORT_YEL   = 3'd4;
  localparam logic [2:0] F_SHORT_CLR   = 3'd5;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

endpackage

// File: rtl/road_seq_check.sv
// Per-road sequence checker: holds previous code and yellow dwell.
// Ports: clk, clear_n, code in; illegal_seq, short_yellow, went_green out.
module road_seq_check
  import light_pkg::*;
#(
  parameter int         MIN_YELLOW = 3,
  parameter logic [1:0] PREV_RST   = RED
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [1:0] code,
  output logic       illegal_seq,
  output logic       short_yellow,
  output logic       went_green
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);

  logic [1:0]    prev;
  logic [YW-1:0] yel_cnt;
  logic          legal;

  always_comb begin
    legal = (code == prev)
         || (prev == GREEN  && code == YELLOW)
         || (prev == YELLOW && code == RED)
         || (prev == RED    && code == GREEN);
  end

  assign illegal_seq  = !legal;
  // yel_cnt counts the YELLOW samples preceding this one
  assign short_yellow = (prev == YELLOW) && (code == RED)
                     && (yel_cnt < YMAX);
  assign went_green   = (prev == RED) && (code == GREEN);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      prev    <= PREV_RST;
      yel_cnt <= '0;
    end else begin
      prev <= code;
      if (code != YELLOW)
        yel_cnt <= '0;
      else if (yel_cnt != YMAX)
        yel_cnt <= yel_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/light_monitor.sv
// Safety monitor on the intersection light codes; latches first fault.
// Ports: clk, clear_n, hwy, cntry, fault_clr in; fault, fault_code, in_sync, cntry_grants out.
module light_monitor
  import light_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MIN_ALLRED = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       hwy,
  input  logic [1:0]       cntry,
  input  logic             fault_clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             in_sync,
  output logic [CNT_W-1:0] cntry_grants
);

  localparam int AW = $clog2(MIN_ALLRED + 1);
  localparam logic [AW-1:0] AMAX = AW'(MIN_ALLRED);

  mon_state_t    state;
  logic [AW-1:0] allred_cnt;
  logic          h_ill, h_sy, h_gg;
  logic          c_ill, c_sy, c_gg;
  logic          invalid, conflict, short_clr;
  logic [2:0]    code_now;

  road_seq_check #(
    .MIN_YELLOW (MIN_YELLOW),
    .PREV_RST   (GREEN)
  ) u_hwy (
    .clk          (clk),
    .clear_n      (clear_n),
    .code         (hwy),
    .illegal_seq  (h_ill),
    .short_yellow (h_sy),
    .went_green   (h_gg)
  );

  road_seq_check #(
    .MIN_YELLOW (MIN_YELLOW),
    .PREV_RST   (RED)
  ) u_cntry (
    .clk          (clk),
    .clear_n      (clear_n),
    .code         (cntry),
    .illegal_seq  (c_ill),
    .short_yellow (c_sy),
    .went_green   (c_gg)
  );

  assign invalid   = (hwy == BADLT) || (cntry == BADLT);
  assign conflict  = (hwy != RED) && (cntry != RED);
  // all-red count is the value built up before this sample
  assign short_clr = (h_gg || c_gg) && (allred_cnt < AMAX);

  always_comb begin
    code_now = F_NONE;
    if (invalid)
      code_now = F_INVALID;
    else if (conflict)
      code_now = F_CONFLICT;
    else if (h_ill || c_ill)
      code_now = F_ILLEGAL_SEQ;
    else if (h_sy || c_sy)
      code_now = F_SHORT_YEL;
    else if (short_clr)
      code_now = F_SHORT_CLR;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      allred_cnt <= '0;
    end else if (hwy != RED || cntry != RED) begin
      allred_cnt <= '0;
    end else if (allred_cnt != AMAX) begin
      allred_cnt <= allred_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state        <= SYNC;
      fault        <= 1'b0;
      fault_code   <= F_NONE;
      in_sync      <= 1'b0;
      cntry_grants <= '0;
    end else begin
      unique case (state)
        SYNC: begin
          if (hwy == GREEN && cntry == RED) begin
            state   <= RUN;
            in_sync <= 1'b1;
          end
        end
        RUN: begin
          if (code_now != F_NONE) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= code_now;
            in_sync    <= 1'b0;
          end else if (c_gg && cntry_grants != '1) begin
            cntry_grants <= cntry_grants + 1'b1;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state      <= SYNC;
            fault      <= 1'b0;
            fault_code <= F_NONE;
          end
        end
        default: begin
          state   <= SYNC;
          in_sync <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_monitor.sv
// Directed self-checking bench for light_monitor.
// Linear stimulus, immediate assertions at each check.
module tb_light_monitor;

  logic       clk;
  logic       clear_n;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       in_sync;
  logic [7:0] cntry_grants;

  int tests;
  int fails;

  light_monitor #(
    .MIN_YELLOW (3),
    .MIN_ALLRED (2),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .hwy          (hwy),
    .cntry        (cntry),
    .fault_clr    (fault_clr),
    .fault        (fault),
    .fault_code   (fault_code),
    .in_sync      (in_sync),
    .cntry_grants (cntry_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int h, input int c);
    hwy   = 2'(h);
    cntry = 2'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic legal_cycle();
    repeat (3) step(1, 0);
    repeat (2) step(0, 0);
    step(0, 2);
    repeat (3) step(0, 1);
    repeat (2) step(0, 0);
    step(2, 0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    clear_n   = 1'b0;
    fault_clr = 1'b0;
    hwy       = 2'd2;
    cntry     = 2'd0;
    #1;

    step(2, 0);
    step(2, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_code", 32'(fault_code), 0);
    chk("rst_insync", 32'(in_sync), 0);
    chk("rst_grants", 32'(cntry_grants), 0);

    clear_n = 1'b1;
    step(2, 0);
    chk("sync_insync", 32'(in_sync), 1);
    chk("sync_fault", 32'(fault), 0);

    repeat (3) step(1, 0);
    repeat (2) step(0, 0);
    step(0, 2);
    chk("grant_first", 32'(cntry_grants), 1);
    repeat (3) step(0, 1);
    repeat (2) step(0, 0);
    step(2, 0);
    chk("cyc_fault", 32'(fault), 0);
    chk("cyc_grants", 32'(cntry_grants), 1);
    chk("cyc_insync", 32'(in_sync), 1);

    step(1, 0);
    step(1, 0);
    chk("sy_pre_fault", 32'(fault), 0);
    step(0, 0);
    chk("sy_fault", 32'(fault), 1);
    chk("sy_code", 32'(fault_code), 4);
    chk("sy_insync", 32'(in_sync), 0);

    step(0, 2);
    chk("frz_code", 32'(fault_code), 4);

    fault_clr = 1'b1;
    step(0, 2);
    fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 0);
    chk("clr_code", 32'(fault_code), 0);
    chk("clr_insync", 32'(in_sync), 0);
    step(0, 2);
    step(1, 0);
    chk("resync_wait", 32'(in_sync), 0);
    step(2, 0);
    chk("resync", 32'(in_sync), 1);

    fault_clr = 1'b1;
    step(2, 0);
    fault_clr = 1'b0;
    chk("clr_in_run", 32'(in_sync), 1);

    step(1, 2);
    chk("cf_fault", 32'(fault), 1);
    chk("cf_code", 32'(fault_code), 2);
    step(3, 0);
    chk("cf_hold_code", 32'(fault_code), 2);

    fault_clr = 1'b1;
    step(3, 3);
    fault_clr = 1'b0;
    chk("clr_wins", 32'(fault), 0);
    step(2, 0);
    chk("resync2", 32'(in_sync), 1);
    chk("grants_kept", 32'(cntry_grants), 1);

    step(1, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 2);
    chk("short_clr_code", 32'(fault_code), 5);
    fault_clr = 1'b1;
    step(0, 2);
    fault_clr = 1'b0;
    step(2, 0);
    chk("resync3", 32'(in_sync), 1);

    repeat (254) legal_cycle();
    chk("sat_reach", 32'(cntry_grants), 255);
    chk("sat_fault", 32'(fault), 0);
    legal_cycle();
    chk("sat_hold", 32'(cntry_grants), 255);

    step(1, 0);
    step(0, 0);
    chk("pre_rst_fault", 32'(fault), 1);
    clear_n = 1'b0;
    step(0, 0);
    chk("mid_rst_fault", 32'(fault), 0);
    chk("mid_rst_code", 32'(fault_code), 0);
    chk("mid_rst_insync", 32'(in_sync), 0);
    chk("mid_rst_grants", 32'(cntry_grants), 0);
    clear_n = 1'b1;
    step(2, 0);
    step(2, 0);
    chk("post_rst_run", 32'(in_sync), 1);
    chk("post_rst_fault", 32'(fault), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
